np_iomem_uart: RTL and testbench

Parametrised UART peripheral on the picosoc iomem bus, replacing the fixed built-in serial port with a buffered, interrupt-capable channel. Provides TX and RX FIFOs of configurable depth, a runtime-programmable baud divider, sticky error flags and a level interrupt for an `irq_5..7` input. Multiple instances at different `BASE_ADDR` values give additional serial channels beside the console.

---
 rtl/np_iomem_uart_if.sv | 19 +
 rtl/np_iomem_uart.sv | 211 +++++++++++++++++++++
 tb/tb_np_iomem_uart.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/np_iomem_uart_if.sv
// rtl/np_iomem_uart_if.sv - picosoc iomem bus bundle for the UART register window
interface np_iomem_uart_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/np_iomem_uart.sv
// rtl/np_iomem_uart.sv - buffered iomem UART with TX/RX FIFOs, baud divider, sticky errors, IRQ
module np_iomem_uart #(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter int          DIV_RESET  = 104
) (
  input  logic              CLK,
  input  logic              RST,
  np_iomem_uart_if.slave    bus,
  input  logic              SERIAL_RX,
  output logic              SERIAL_TX,
  output logic              IRQ
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_RUN} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [15:0] div_q, div_next;
  logic [2:0]  ctrl_q;
  logic        ovr_q, ferr_q;

  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0]   tx_cnt, rx_cnt;

  tx_state_t   tx_state;
  logic [9:0]  tx_frame;
  logic [15:0] tx_div, tx_clk;
  logic [3:0]  tx_bit;

  rx_state_t   rx_state;
  logic        rx_s1, rx_s2, rx_prev;
  logic [15:0] rx_div, rx_clk;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;

  logic        acc, wr, tx_full, tx_empty, rx_ne, rx_full, tx_idle;
  logic        tx_push, tx_pop, rx_push, rx_pop, rx_stop_hit, rx_line;
  logic [1:0]  reg_sel;
  logic [8:0]  rx_occ;
  logic [31:0] status;
  logic        unused_bits;

  // A request is accepted once: ready itself masks the still-held valid.
  assign acc      = bus.iomem_valid && (bus.iomem_addr[31:4] == BASE_ADDR[31:4]) && !bus.iomem_ready;
  assign wr       = |bus.iomem_wstrb;
  assign reg_sel  = bus.iomem_addr[3:2];
  assign tx_full  = (tx_cnt == FULL);
  assign tx_empty = (tx_cnt == '0);
  assign rx_ne    = (rx_cnt != '0);
  assign rx_full  = (rx_cnt == FULL);
  assign tx_idle  = tx_empty && (tx_state == TX_IDLE);
  assign tx_push  = acc && wr && (reg_sel == 2'd0) && bus.iomem_wstrb[0] && !tx_full;
  assign tx_pop   = (tx_state == TX_IDLE) && !tx_empty;
  assign rx_pop   = acc && !wr && (reg_sel == 2'd0) && rx_ne;
  assign rx_stop_hit = (rx_state == RX_STOP) && (rx_clk == rx_div);
  assign rx_push  = rx_stop_hit && rx_s2 && (!rx_full || rx_pop);
  assign rx_line  = ctrl_q[2] ? SERIAL_TX : SERIAL_RX;
  assign rx_occ   = 9'(rx_cnt);
  assign status   = {16'b0, rx_occ[7:0], 3'b0, ferr_q, ovr_q, tx_idle, tx_full, rx_ne};
  assign unused_bits = ^{bus.iomem_addr[1:0], bus.iomem_wdata[31:16], bus.iomem_wstrb[3:2], rx_occ[8]};

  always_comb begin
    div_next = div_q;
    if (bus.iomem_wstrb[0]) div_next[7:0]  = bus.iomem_wdata[7:0];
    if (bus.iomem_wstrb[1]) div_next[15:8] = bus.iomem_wdata[15:8];
    if (div_next < 16'd4)   div_next       = 16'd4;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.iomem_ready <= 1'b0;
      bus.iomem_rdata <= '0;
      div_q  <= 16'(DIV_RESET);
      ctrl_q <= '0;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      IRQ    <= 1'b0;
    end else begin
      bus.iomem_ready <= acc;
      bus.iomem_rdata <= '0;
      if (acc) begin
        case (reg_sel)
          2'd0: if (!wr) bus.iomem_rdata <= rx_ne ? {24'b0, rx_mem[rx_rp]} : 32'hFFFF_FFFF;
          2'd1: begin
            bus.iomem_rdata <= {16'b0, div_q};
            if (wr) div_q <= div_next;
          end
          2'd2: bus.iomem_rdata <= status;
          default: begin
            bus.iomem_rdata <= {29'b0, ctrl_q};
            if (bus.iomem_wstrb[0]) ctrl_q <= bus.iomem_wdata[2:0];
          end
        endcase
      end
      // A new error event in the same cycle as a clear wins.
      if (acc && (reg_sel == 2'd2) && bus.iomem_wstrb[0]) begin
        if (bus.iomem_wdata[3]) ovr_q  <= 1'b0;
        if (bus.iomem_wdata[4]) ferr_q <= 1'b0;
      end
      if (rx_stop_hit && !rx_s2) ferr_q <= 1'b1;
      if (rx_stop_hit && rx_s2 && rx_full && !rx_pop) ovr_q <= 1'b1;
      IRQ <= (ctrl_q[0] && rx_ne) || (ctrl_q[1] && tx_idle);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      rx_cnt <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wp] <= bus.iomem_wdata[7:0];
    if (rx_push) rx_mem[rx_wp] <= rx_shift;
  end

  // Frame is shifted out LSB first; ones shifted in keep the line high after stop.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_state  <= TX_IDLE;
      SERIAL_TX <= 1'b1;
      tx_frame  <= '1;
      tx_div    <= 16'd4;
      tx_clk    <= '0;
      tx_bit    <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: if (!tx_empty) begin
          tx_frame <= {1'b1, tx_mem[tx_rp], 1'b0};
          tx_div   <= div_q;
          tx_state <= TX_LOAD;
        end
        TX_LOAD: begin
          SERIAL_TX <= tx_frame[0];
          tx_frame  <= {1'b1, tx_frame[9:1]};
          tx_clk    <= 16'd1;
          tx_bit    <= '0;
          tx_state  <= TX_RUN;
        end
        default: if (tx_clk == tx_div) begin
          tx_clk <= 16'd1;
          if (tx_bit == 4'd9) begin
            tx_state <= TX_IDLE;
          end else begin
            SERIAL_TX <= tx_frame[0];
            tx_frame  <= {1'b1, tx_frame[9:1]};
            tx_bit    <= tx_bit + 4'd1;
          end
        end else begin
          tx_clk <= tx_clk + 16'd1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_div   <= 16'd4;
      rx_clk   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1   <= rx_line;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_s2) begin
          rx_div   <= div_q;
          rx_clk   <= 16'd1;
          rx_state <= RX_START;
        end
        RX_START: if (rx_clk == {1'b0, rx_div[15:1]}) begin
          rx_clk   <= 16'd1;
          rx_bit   <= '0;
          rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          rx_clk <= rx_clk + 16'd1;
        end
        RX_DATA: if (rx_clk == rx_div) begin
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_clk   <= 16'd1;
          rx_bit   <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
        end else begin
          rx_clk <= rx_clk + 16'd1;
        end
        default: if (rx_clk == rx_div) begin
          rx_state <= RX_IDLE;
        end else begin
          rx_clk <= rx_clk + 16'd1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_np_iomem_uart.sv
// tb/tb_np_iomem_uart.sv - directed self-checking bench for np_iomem_uart
`timescale 1ns/1ps
module tb_np_iomem_uart;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic serial_rx = 1'b1;
  logic serial_tx;
  logic irq;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  np_iomem_uart_if bus ();

  np_iomem_uart dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .SERIAL_RX (serial_rx),
    .SERIAL_TX (serial_tx),
    .IRQ       (irq)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic bus_op(input logic [3:0] off, input logic [3:0] strb, input logic [31:0] data,
                        output logic [31:0] rd);
    int n;
    @(negedge CLK);
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = 32'h0300_0000 | {28'b0, off};
    bus.iomem_wstrb = strb;
    bus.iomem_wdata = data;
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (!bus.iomem_ready && n < 20);
    check("bus_ready", {31'b0, bus.iomem_ready}, 32'd1);
    rd = bus.iomem_rdata;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'b0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [3:0] strb, input logic [31:0] data);
    logic [31:0] dummy;
    bus_op(off, strb, data, dummy);
  endtask

  task automatic rd(input logic [3:0] off, output logic [31:0] v);
    bus_op(off, 4'b0, 32'b0, v);
  endtask

  task automatic poll_status(input logic [31:0] mask, input logic [31:0] want, output logic [31:0] st);
    int n;
    n = 0;
    do begin
      rd(4'h8, st);
      n++;
    end while (((st & mask) != want) && n < 400);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    @(posedge CLK); #1;
    for (int i = 0; i < 10; i++) begin
      serial_rx = f[i];
      repeat (8) @(posedge CLK);
      #1;
    end
    serial_rx = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic [9:0]  bits;
    int          t0;
    int          nready;
    int          nlow;

    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'b0;
    bus.iomem_addr  = 32'b0;
    bus.iomem_wdata = 32'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_tx",    {31'b0, serial_tx}, 32'd1);
    check("rst_irq",   {31'b0, irq}, 32'd0);
    check("rst_ready", {31'b0, bus.iomem_ready}, 32'd0);
    check("rst_rdata", bus.iomem_rdata, 32'd0);
    @(negedge CLK);
    RST = 1'b1;

    rd(4'h4, v); check("div_reset", v, 32'd104);
    rd(4'h8, v); check("status_reset", v, 32'h0000_0004);

    @(negedge CLK);
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = 32'h0400_0008;
    nready = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      if (bus.iomem_ready) nready++;
      check("undecoded_rdata", bus.iomem_rdata, 32'd0);
    end
    check("undecoded_ready", nready, 32'd0);
    bus.iomem_valid = 1'b0;

    wr(4'h4, 4'b0011, 32'd1);  rd(4'h4, v); check("div_min", v, 32'd4);
    wr(4'h4, 4'b0011, 32'd8);  rd(4'h4, v); check("div_8", v, 32'd8);

    // Single TX frame of A5
    wr(4'h0, 4'b0001, 32'h0000_00A5);
    @(posedge CLK); #1;
    check("tx_pre_start", {31'b0, serial_tx}, 32'd1);
    @(posedge CLK); #1;
    check("tx_start_edge", {31'b0, serial_tx}, 32'd0);
    repeat (4) @(posedge CLK);
    #1;
    for (int k = 0; k < 10; k++) begin
      bits[k] = serial_tx;
      repeat (8) @(posedge CLK);
      #1;
    end
    check("tx_frame_bits", {22'b0, bits}, {22'b0, 10'h34A});
    repeat (10) @(posedge CLK);
    rd(4'h8, v); check("tx_idle_after", v, 32'h0000_0004);

    // 17 frames into a 16-deep RX FIFO
    for (int i = 0; i < 17; i++) send_frame(8'h3C, 1'b1);
    rd(4'h8, v); check("rx_overrun_status", v, 32'h0000_100D);
    for (int i = 0; i < 16; i++) begin
      rd(4'h0, v); check("rx_data_3c", v, 32'h0000_003C);
    end
    rd(4'h0, v); check("rx_empty_read", v, 32'hFFFF_FFFF);
    wr(4'h8, 4'b0001, 32'h0000_0008);
    rd(4'h8, v); check("ovr_cleared", v, 32'h0000_0004);

    // Framing error, then clear, then glitch rejection
    send_frame(8'h55, 1'b0);
    rd(4'h8, v); check("frame_error", v, 32'h0000_0014);
    wr(4'h8, 4'b0001, 32'h0000_0010);
    rd(4'h8, v); check("ferr_cleared", v, 32'h0000_0004);
    @(posedge CLK); #1;
    serial_rx = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    serial_rx = 1'b1;
    repeat (100) @(posedge CLK);
    rd(4'h8, v); check("glitch_rejected", v, 32'h0000_0004);

    // TX-idle interrupt
    wr(4'hC, 4'b0001, 32'h0000_0002);
    check("irq_txidle_lag", {31'b0, irq}, 32'd0);
    @(posedge CLK); #1;
    check("irq_txidle", {31'b0, irq}, 32'd1);
    wr(4'hC, 4'b0001, 32'h0000_0000);
    @(posedge CLK); #1;
    check("irq_off", {31'b0, irq}, 32'd0);

    // Loopback with RX interrupt
    wr(4'hC, 4'b0001, 32'h0000_0005);
    wr(4'h0, 4'b0001, 32'h0000_0000);
    wr(4'h0, 4'b0001, 32'h0000_00FF);
    wr(4'h0, 4'b0001, 32'h0000_0081);
    check("lb_irq_before", {31'b0, irq}, 32'd0);
    poll_status(32'h0000_0001, 32'h0000_0001, v);
    check("lb_first_landed", v & 32'h1, 32'h1);
    @(posedge CLK); #1;
    check("lb_irq_high", {31'b0, irq}, 32'd1);
    poll_status(32'h0000_FF00, 32'h0000_0300, v);
    check("lb_occ3", v & 32'hFF00, 32'h0000_0300);
    rd(4'h0, v); check("lb_byte0", v, 32'h0000_0000);
    rd(4'h0, v); check("lb_byte1", v, 32'h0000_00FF);
    rd(4'h0, v); check("lb_byte2", v, 32'h0000_0081);
    check("lb_irq_last_pop", {31'b0, irq}, 32'd1);
    @(posedge CLK); #1;
    check("lb_irq_fall", {31'b0, irq}, 32'd0);
    wr(4'hC, 4'b0001, 32'h0000_0000);
    repeat (30) @(posedge CLK);

    // Reset during TX data bit 4, with a second byte queued
    wr(4'h0, 4'b0001, 32'h0000_00A5);
    t0 = cyc;
    wr(4'h0, 4'b0001, 32'h0000_005A);
    while (cyc < t0 + 46) begin
      @(posedge CLK); #1;
    end
    check("tx_bit4_low", {31'b0, serial_tx}, 32'd0);
    RST = 1'b0;
    #1;
    check("rst_tx_async", {31'b0, serial_tx}, 32'd1);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    rd(4'h8, v); check("post_rst_status", v, 32'h0000_0004);
    rd(4'h4, v); check("post_rst_div", v, 32'd104);
    nlow = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge CLK); #1;
      if (!serial_tx) nlow++;
    end
    check("post_rst_tx_quiet", nlow, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
